alu_exec_unit: RTL and testbench

- Execution-stage ALU that consumes the 5-bit ALU control code produced by the ALU control decoder.
- Has a valid/ready handshake on both the operand side and the result side.
- Arithmetic, logic, compare, branch and LUI ops take one cycle.
- Shifts run iteratively, one bit position per cycle, to keep the datapath small. Results are registered and held until the downstream stage accepts them.

---
 rtl/alu_exec_unit.sv | 194 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready handshakes on both sides.
// Single-cycle arithmetic/logic/compare/branch/LUI; shifts iterate one bit per cycle.
module alu_exec_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         alu_ctrl,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               zero,
    output logic               branch_taken,
    output logic               illegal_op
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_BLT  = 5'd12;
    localparam logic [4:0] OP_BGE  = 5'd13;
    localparam logic [4:0] OP_BLTU = 5'd14;
    localparam logic [4:0] OP_BGEU = 5'd15;
    localparam logic [4:0] OP_LUI  = 5'd16;

    logic [1:0]         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    shreg_q, shreg_d;
    logic [4:0]         sop_q, sop_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;
    logic               br_q, br_d;
    logic               ill_q, ill_d;
    logic               out_valid_q, out_valid_d;

    logic [XLEN-1:0]    alu_res_c;
    logic               taken_c;
    logic               illegal_c;
    logic               is_shift_c;
    logic               lt_s_c;
    logic               lt_u_c;
    logic               eq_c;
    logic [XLEN-1:0]    shift_next_c;

    assign in_ready     = (state_q == ST_IDLE) & ~rst;
    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign branch_taken = br_q;
    assign illegal_op   = ill_q;

    // Single-cycle datapath on the presented operands
    always_comb begin
        lt_s_c     = $signed(op_a) < $signed(op_b);
        lt_u_c     = op_a < op_b;
        eq_c       = op_a == op_b;
        alu_res_c  = '0;
        taken_c    = 1'b0;
        illegal_c  = 1'b0;
        is_shift_c = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
        case (alu_ctrl)
            OP_ADD:  alu_res_c = op_a + op_b;
            OP_SUB:  alu_res_c = op_a - op_b;
            OP_SLT:  alu_res_c = XLEN'(lt_s_c);
            OP_SLTU: alu_res_c = XLEN'(lt_u_c);
            OP_XOR:  alu_res_c = op_a ^ op_b;
            OP_OR:   alu_res_c = op_a | op_b;
            OP_AND:  alu_res_c = op_a & op_b;
            OP_BEQ:  taken_c   = eq_c;
            OP_BNE:  taken_c   = ~eq_c;
            OP_BLT:  taken_c   = lt_s_c;
            OP_BGE:  taken_c   = ~lt_s_c;
            OP_BLTU: taken_c   = lt_u_c;
            OP_BGEU: taken_c   = ~lt_u_c;
            OP_LUI:  alu_res_c = op_b;
            OP_SLL, OP_SRL, OP_SRA: alu_res_c = '0;
            default: illegal_c = 1'b1;
        endcase
        if (alu_ctrl >= OP_BEQ && alu_ctrl <= OP_BGEU) begin
            alu_res_c = XLEN'(taken_c);
        end
    end

    // One-bit step of the iterative shifter
    always_comb begin
        case (sop_q)
            OP_SLL:  shift_next_c = {shreg_q[XLEN-2:0], 1'b0};
            OP_SRL:  shift_next_c = {1'b0, shreg_q[XLEN-1:1]};
            default: shift_next_c = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        sop_d       = sop_q;
        result_d    = result_q;
        br_d        = br_q;
        ill_d       = ill_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift_c) begin
                        shreg_d = op_a;
                        cnt_d   = op_b[SHAMT_W-1:0];
                        sop_d   = alu_ctrl;
                        if (op_b[SHAMT_W-1:0] == '0) begin
                            result_d    = op_a;
                            br_d        = 1'b0;
                            ill_d       = 1'b0;
                            out_valid_d = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        result_d    = alu_res_c;
                        br_d        = taken_c;
                        ill_d       = illegal_c;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                shreg_d = shift_next_c;
                cnt_d   = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d    = shift_next_c;
                    br_d        = 1'b0;
                    ill_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            sop_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            sop_q       <= sop_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            br_q        <= br_d;
            ill_q       <= ill_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: reference model fills a queue at drive time,
// results are popped and compared when the unit presents them.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic        illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        br;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero),
        .branch_taken(branch_taken), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of the operation table
    function automatic exp_t model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [4:0] sh;
        sh    = b[4:0];
        e.res = 32'h0;
        e.br  = 1'b0;
        e.ill = 1'b0;
        e.lat = 1;
        case (c)
            5'd0:  e.res = a + b;
            5'd1:  e.res = a - b;
            5'd2:  begin e.res = a << sh; e.lat = int'(sh) + 1; end
            5'd3:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
            5'd5:  e.res = a ^ b;
            5'd6:  begin e.res = a >> sh; e.lat = int'(sh) + 1; end
            5'd7:  begin e.res = $signed(a) >>> sh; e.lat = int'(sh) + 1; end
            5'd8:  e.res = a | b;
            5'd9:  e.res = a & b;
            5'd10: e.br = (a == b);
            5'd11: e.br = (a != b);
            5'd12: e.br = ($signed(a) < $signed(b));
            5'd13: e.br = ($signed(a) >= $signed(b));
            5'd14: e.br = (a < b);
            5'd15: e.br = (a >= b);
            5'd16: e.res = b;
            default: e.ill = 1'b1;
        endcase
        if (c >= 5'd10 && c <= 5'd15) e.res = {31'h0, e.br};
        return e;
    endfunction

    task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   g;
        int   lat;
        int   busy_rdy;
        logic [31:0] held;
        sb.push_back(model(c, a, b));
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = 5'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat      = 0;
        busy_rdy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) busy_rdy++;
        end while (!out_valid && lat < 100);
        check("out_valid_rise", 32'(out_valid), 32'd1);
        check("busy_in_ready", 32'(busy_rdy), 32'd0);
        e = sb.pop_front();
        check("result", result, e.res);
        check("zero", 32'(zero), 32'(e.res == 32'h0));
        check("branch_taken", 32'(branch_taken), 32'(e.br));
        check("illegal_op", 32'(illegal_op), 32'(e.ill));
        check("latency", 32'(lat), 32'(e.lat));
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, held);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 5'd0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_branch", 32'(branch_taken), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);

        run_op(5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(5'd1,  32'd5,         32'd7,         0);
        run_op(5'd3,  32'hFFFF_FFFF, 32'd1,         0);
        run_op(5'd4,  32'hFFFF_FFFF, 32'd1,         0);
        run_op(5'd12, 32'hFFFF_FFFF, 32'd1,         0);
        run_op(5'd14, 32'hFFFF_FFFF, 32'd1,         0);
        run_op(5'd15, 32'hFFFF_FFFF, 32'd1,         0);
        run_op(5'd7,  32'h8000_0000, 32'd31,        0);
        run_op(5'd6,  32'h8000_0000, 32'd31,        0);
        run_op(5'd2,  32'h1234_5678, 32'h0000_0020, 0);
        run_op(5'd16, 32'h0,         32'hABCD_E000, 5);
        run_op(5'b10001, 32'h1111_1111, 32'h2222_2222, 0);
        run_op(5'd7,  32'hF000_0000, 32'd3,         0);
        run_op(5'd10, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 0);

        // Abort an in-flight shift with reset; its result must never appear
        alu_ctrl = 5'd2;
        op_a     = 32'h0000_0001;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midshift_rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("midshift_out_valid", 32'(out_valid), 32'd0);
        check("midshift_result", result, 32'h0);
        check("midshift_zero", 32'(zero), 32'd1);
        check("midshift_branch", 32'(branch_taken), 32'd0);
        check("midshift_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midshift_release_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("aborted_never_valid", 32'(seen), 32'd0);

        run_op(5'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);

        for (int i = 0; i < 24; i++) begin
            run_op(5'($urandom_range(0, 20)), $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
